normalizer_16_bit: RTL and testbench

NORMALIZER_16_BIT -- requirements
Module: normalizer_16_bit

---
 rtl/normalizer_pkg.sv | 35 +++
 rtl/normalizer_16_bit_if.sv | 34 +++
 rtl/normalizer_16_bit.sv | 112 +++++++++++
 tb/tb_normalizer_16_bit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/normalizer_pkg.sv
// ============================================================================
// Module   : normalizer_pkg
// Purpose  : Shared constants, state encoding and state decode for the
//            16-bit leading-one normalizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package normalizer_pkg;

  // Data width and shift-count width; 16/4 is the only supported pairing.
  localparam int W  = 16;
  localparam int AW = 4;

  // FSM encoding; 2'd3 is never produced and is treated as IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Map a raw 2-bit code onto a legal state so the unused code falls to IDLE.
  function automatic state_t decode_state(input logic [1:0] code);
    state_t s;
    case (code)
      2'd1:    s = SHIFT;
      2'd2:    s = DONE;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage : normalizer_pkg

`default_nettype wire

// File: rtl/normalizer_16_bit_if.sv
// ============================================================================
// Module   : normalizer_16_bit_if
// Purpose  : Request/result bundle of the normalizer. The master side issues
//            start/a, the slave side returns busy/done/y/amt/zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface normalizer_16_bit_if #(
  parameter int W  = normalizer_pkg::W,
  parameter int AW = normalizer_pkg::AW
);

  logic          start;
  logic [W-1:0]  a;
  logic          busy;
  logic          done;
  logic [W-1:0]  y;
  logic [AW-1:0] amt;
  logic          zero;

  modport master (
    output start, a,
    input  busy, done, y, amt, zero
  );

  modport slave (
    input  start, a,
    output busy, done, y, amt, zero
  );

endinterface : normalizer_16_bit_if

`default_nettype wire

// File: rtl/normalizer_16_bit.sv
// ============================================================================
// Module   : normalizer_16_bit
// Purpose  : Iterative leading-one normalizer. A captured operand is shifted
//            left one bit per cycle until its MSB is set; the result word and
//            the number of shifts applied are then registered and done pulses.
//            A zero operand skips shifting and reports zero=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module normalizer_16_bit
  import normalizer_pkg::*;
#(
  parameter int W  = normalizer_pkg::W,
  parameter int AW = normalizer_pkg::AW
) (
  input  logic                clk,
  input  logic                reset_n,
  normalizer_16_bit_if.slave  bus
);

  localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  work;
  logic [W-1:0]  work_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_next;
  logic [W-1:0]  y_reg;
  logic [W-1:0]  y_next;
  logic [AW-1:0] amt_reg;
  logic [AW-1:0] amt_next;
  logic          zero_reg;
  logic          zero_next;
  state_t        state_dec;

  // Fold any illegal state code back onto IDLE before it drives decisions.
  assign state_dec = decode_state(state);

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      y_reg    <= '0;
      amt_reg  <= '0;
      zero_reg <= 1'b0;
    end else begin
      state    <= state_next;
      work     <= work_next;
      cnt      <= cnt_next;
      y_reg    <= y_next;
      amt_reg  <= amt_next;
      zero_reg <= zero_next;
    end
  end

  // Next-state and datapath updates; everything holds unless a branch moves it.
  always_comb begin
    state_next = state;
    work_next  = work;
    cnt_next   = cnt;
    y_next     = y_reg;
    amt_next   = amt_reg;
    zero_next  = zero_reg;
    case (state_dec)
      SHIFT: begin
        if (work[W-1]) begin
          // Leading one reached: publish the result.
          y_next     = work;
          amt_next   = cnt;
          zero_next  = 1'b0;
          state_next = DONE;
        end else begin
          // A nonzero operand needs at most W-1 shifts, so cnt cannot wrap.
          work_next = {work[W-2:0], 1'b0};
          cnt_next  = cnt + CNT_ONE;
        end
      end
      DONE: begin
        // Single-cycle result strobe; start is deliberately ignored here.
        state_next = IDLE;
      end
      default: begin
        // IDLE: only here is a new operand accepted.
        if (bus.start) begin
          work_next = bus.a;
          cnt_next  = '0;
          if (bus.a == '0) begin
            y_next     = '0;
            amt_next   = '0;
            zero_next  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
    endcase
  end

  assign bus.busy = (state_dec == SHIFT) || (state_dec == DONE);
  assign bus.done = (state_dec == DONE);
  assign bus.y    = y_reg;
  assign bus.amt  = amt_reg;
  assign bus.zero = zero_reg;

endmodule : normalizer_16_bit

`default_nettype wire

// File: tb/tb_normalizer_16_bit.sv
// ============================================================================
// Module   : tb_normalizer_16_bit
// Purpose  : Directed self-checking bench for normalizer_16_bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_normalizer_16_bit;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  normalizer_16_bit_if bus ();

  normalizer_16_bit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present an operand with start for one accepting edge (edge k); returns #1 after it.
  task automatic launch(input logic [15:0] val);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = val;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after edge k until done is seen at a falling edge, within a budget.
  task automatic wait_done(output int edges, output bit timed_out);
    edges     = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
      if (edges >= 40) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.y, bus.amt, bus.zero} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b y=%h amt=%h zero=%b, required all zero",
               bus.busy, bus.done, bus.y, bus.amt, bus.zero);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_normalize(input string name, input logic [15:0] val,
                                input logic [15:0] exp_y, input logic [3:0] exp_amt,
                                input logic exp_zero, input int exp_edges);
    int edges;
    bit to;
    launch(val);
    wait_done(edges, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL %s_timeout: done never seen within 40 edges", name);
      return;
    end
    if (edges !== exp_edges) begin
      miscompares++;
      $display("FAIL %s_latency: done after %0d edges, required %0d", name, edges, exp_edges);
    end
    vectors++;
    if (bus.y !== exp_y || bus.amt !== exp_amt || bus.zero !== exp_zero || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_result: y=%h amt=%0d zero=%b busy=%b, required y=%h amt=%0d zero=%b busy=1",
               name, bus.y, bus.amt, bus.zero, bus.busy, exp_y, exp_amt, exp_zero);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_pulse: done=%b busy=%b one cycle later, required 0 0",
               name, bus.done, bus.busy);
    end
  endtask

  // With start low the outputs must hold regardless of the operand bus.
  task automatic test_idle_hold(input logic [15:0] exp_y, input logic [3:0] exp_amt,
                                input logic exp_zero);
    int bad;
    bad = 0;
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.a = 16'hFFFF ^ 16'(i);
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y !== exp_y ||
          bus.amt !== exp_amt || bus.zero !== exp_zero) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_hold: %0d cycles with changed outputs (y=%h amt=%0d zero=%b), required y=%h amt=%0d zero=%b",
               bad, bus.y, bus.amt, bus.zero, exp_y, exp_amt, exp_zero);
    end
  endtask

  // start held high through SHIFT and DONE must not restart the operation.
  task automatic test_start_while_busy();
    int pulses;
    int edges;
    pulses = 0;
    edges  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    @(posedge clk);
    #1;
    bus.a = 16'hFFFF;
    while (edges < 40) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
      @(posedge clk);
      edges++;
    end
    if (bus.done === 1'b1) pulses++;
    vectors++;
    if (edges !== 16 || bus.y !== 16'h8000 || bus.amt !== 4'd15 || bus.zero !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_result: edges=%0d y=%h amt=%0d zero=%b, required 16 8000 15 0",
               edges, bus.y, bus.amt, bus.zero);
    end
    // Leave DONE with start still high, then drop it once back in IDLE.
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_pulses: %0d done pulses busy=%b, required 1 pulse busy=0",
               pulses, bus.busy);
    end
  endtask

  // Reset mid-SHIFT abandons the operation; a fresh operand then works.
  task automatic test_reset_mid_shift();
    int pulses;
    int edges;
    bit to;
    pulses = 0;
    launch(16'h0001);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.y, bus.amt, bus.zero} !== 23'd0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b y=%h amt=%h zero=%b, required all zero",
               bus.busy, bus.done, bus.y, bus.amt, bus.zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_abandon: %0d cycles busy/done after reset, required 0", pulses);
    end
    launch(16'h4000);
    wait_done(edges, to);
    vectors++;
    if (to || edges !== 2 || bus.y !== 16'h8000 || bus.amt !== 4'd1 || bus.zero !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_op: timeout=%b edges=%0d y=%h amt=%0d zero=%b, required 0 2 8000 1 0",
               to, edges, bus.y, bus.amt, bus.zero);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_normalize("msb_set",  16'h8000, 16'h8000, 4'd0,  1'b0, 1);
    test_normalize("lsb_only", 16'h0001, 16'h8000, 4'd15, 1'b0, 16);
    test_normalize("nibble",   16'h00F0, 16'hF000, 4'd8,  1'b0, 9);
    test_normalize("zero",     16'h0000, 16'h0000, 4'd0,  1'b1, 0);
    test_normalize("after_zero", 16'h7FFF, 16'hFFFE, 4'd1, 1'b0, 2);
    test_normalize("mixed",    16'h1234, 16'h91A0, 4'd3,  1'b0, 4);
    test_idle_hold(16'h91A0, 4'd3, 1'b0);
    test_normalize("pair",     16'h0300, 16'hC000, 4'd6,  1'b0, 7);
    test_start_while_busy();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_normalizer_16_bit

`default_nettype wire
